// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote per bit, runtime frame format,
// valid/ready word output with parity/framing errors, overrun and break detection.
module uart_rx_ovs #(
    parameter int unsigned DATA_MAX = 9,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [3:0]          cfg_data_bits,
    input  logic [1:0]          cfg_parity,
    input  logic [1:0]          cfg_stop_bits,
    input  logic                uart_rx,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic                break_det
);
    localparam int unsigned OS_W = $clog2(OVS);
    localparam logic [OS_W-1:0] SMP0     = OS_W'(OVS/2 - 1);
    localparam logic [OS_W-1:0] SMP1     = OS_W'(OVS/2);
    localparam logic [OS_W-1:0] VOTE     = OS_W'(OVS/2 + 1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0] HALF_END = OS_W'((OVS/2 + 1 + OVS/2) % OVS);

    localparam logic [1:0] STOP1     = 2'd0;
    localparam logic [1:0] STOP2     = 2'd1;
    localparam logic [1:0] STOP_HALF = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state;
    logic                sync1;
    logic                rxs;
    logic                rxs_prev;
    logic [DIV_W-1:0]    div_cnt;
    logic [OS_W-1:0]     os_cnt;
    logic [1:0]          smp;
    logic [3:0]          bit_idx;
    logic [3:0]          n_last;
    logic                par_en;
    logic                par_odd;
    logic [1:0]          stop_mode;
    logic [1:0]          stop_phase;
    logic [DATA_MAX-1:0] shreg;
    logic                par_bit;
    logic                f_perr;
    logic                f_ferr;
    logic                done;

    logic                tick_c;
    logic                vote_c;
    logic                maj_c;
    logic                brk_c;
    logic [3:0]          n_last_c;

    // Two-flop synchroniser plus previous-value register for start-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= uart_rx;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    assign tick_c = (state != S_IDLE) && (state != S_BREAK) && (div_cnt >= cfg_div);
    assign vote_c = tick_c && (os_cnt == VOTE);
    assign maj_c  = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign brk_c  = (shreg == '0) && !(par_en && par_bit) && !maj_c;

    // Index of the last data bit, with the requested width clamped to 5..DATA_MAX
    always_comb begin
        n_last_c = cfg_data_bits - 4'd1;
        if (cfg_data_bits < 4'd5) begin
            n_last_c = 4'd4;
        end else if (32'(cfg_data_bits) > DATA_MAX) begin
            n_last_c = 4'(DATA_MAX - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            os_cnt     <= '0;
            smp        <= '0;
            bit_idx    <= '0;
            n_last     <= '0;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            stop_mode  <= '0;
            stop_phase <= STOP1;
            shreg      <= '0;
            par_bit    <= 1'b0;
            f_perr     <= 1'b0;
            f_ferr     <= 1'b0;
            done       <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            done      <= 1'b0;
            break_det <= 1'b0;

            if ((state == S_IDLE) || (state == S_BREAK) || tick_c) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (tick_c) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                if (os_cnt == SMP0) smp[0] <= rxs;
                if (os_cnt == SMP1) smp[1] <= rxs;
            end

            case (state)
                S_IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state     <= S_START;
                        os_cnt    <= '0;
                        n_last    <= n_last_c;
                        par_en    <= cfg_parity[0];
                        par_odd   <= cfg_parity[1];
                        stop_mode <= cfg_stop_bits;
                    end
                end
                S_START: begin
                    if (vote_c) begin
                        if (maj_c) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            shreg   <= '0;
                            par_bit <= 1'b0;
                            f_perr  <= 1'b0;
                            f_ferr  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (vote_c) begin
                        shreg <= shreg | (DATA_MAX'(maj_c) << bit_idx);
                        if (bit_idx == n_last) begin
                            state      <= par_en ? S_PARITY : S_STOP;
                            stop_phase <= STOP1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (vote_c) begin
                        par_bit    <= maj_c;
                        f_perr     <= (^shreg) ^ maj_c ^ par_odd;
                        state      <= S_STOP;
                        stop_phase <= STOP1;
                    end
                end
                S_STOP: begin
                    case (stop_phase)
                        STOP1: begin
                            if (vote_c) begin
                                if (brk_c) begin
                                    break_det <= 1'b1;
                                    state     <= S_BREAK;
                                end else begin
                                    f_ferr <= !maj_c;
                                    if (stop_mode == 2'd0) begin
                                        done  <= 1'b1;
                                        state <= S_IDLE;
                                    end else if (stop_mode == 2'd1) begin
                                        stop_phase <= STOP_HALF;
                                    end else begin
                                        stop_phase <= STOP2;
                                    end
                                end
                            end
                        end
                        STOP2: begin
                            if (vote_c) begin
                                f_ferr <= f_ferr | !maj_c;
                                done   <= 1'b1;
                                state  <= S_IDLE;
                            end
                        end
                        default: begin
                            // Half stop bit is timed only, never sampled
                            if (tick_c && (os_cnt == HALF_END)) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    endcase
                end
                S_BREAK: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output word register with valid/ready handshake and overrun drop
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data    <= shreg;
                    parity_err <= f_perr;
                    frame_err  <= f_ferr;
                    rx_valid   <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: frame-level model feeds a scoreboard that
// is compared against the DUT outputs every cycle, plus literal spot checks.
module tb_uart_rx_ovs;
    localparam int unsigned DATA_MAX = 9;
    localparam int unsigned OVS      = 16;
    localparam int unsigned DIV_W    = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = 4 * 16 * CLK_NS;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [DIV_W-1:0]    cfg_div = 16'd3;
    logic [3:0]          cfg_data_bits = 4'd8;
    logic [1:0]          cfg_parity = 2'b00;
    logic [1:0]          cfg_stop_bits = 2'd0;
    logic                uart_rx = 1'b1;
    logic [DATA_MAX-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready = 1'b0;
    logic                parity_err;
    logic                frame_err;
    logic                overrun;
    logic                break_det;

    int    n_chk = 0;
    int    n_pass = 0;
    word_t exp_q[$];
    bit    mdl_valid = 1'b0;
    int    exp_ov = 0;
    int    exp_brk = 0;
    int    ov_seen = 0;
    int    brk_seen = 0;

    word_t cur;
    bit    have_word = 1'b0;
    bit    prev_acc = 1'b0;
    bit    ov_prev = 1'b0;
    bit    brk_prev = 1'b0;
    bit    rst_last = 1'b1;

    uart_rx_ovs #(.DATA_MAX(DATA_MAX), .OVS(OVS), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .break_det(break_det)
    );

    always #(CLK_NS/2) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame-level model: decide what the receiver must report, then drive the line
    task automatic send(input logic [8:0] d, input int nb, input bit pen, input logic pbit,
                        input int nstop, input logic sv);
        word_t w;
        logic [8:0] mask;
        bit brk;
        mask   = 9'((1 << nb) - 1);
        w.data = d & mask;
        w.perr = pen ? ((^w.data) ^ pbit ^ cfg_parity[1]) : 1'b0;
        w.ferr = !sv;
        brk    = (w.data == 9'd0) && (!pen || !pbit) && !sv;
        if (brk) exp_brk++;
        else if (mdl_valid) exp_ov++;
        else begin
            exp_q.push_back(w);
            mdl_valid = 1'b1;
        end
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < nb; i++) begin
            uart_rx = d[i];
            #(BIT_NS);
        end
        if (pen) begin
            uart_rx = pbit;
            #(BIT_NS);
        end
        for (int s = 0; s < nstop; s++) begin
            uart_rx = sv;
            #(BIT_NS);
        end
    endtask

    task automatic hold(input logic v, input int nbits);
        uart_rx = v;
        #(nbits * BIT_NS);
    endtask

    task automatic accept();
        int n = 0;
        while (!rx_valid && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("accept_wait_valid", 32'(rx_valid), 32'd1);
        @(posedge clk); #2 rx_ready = 1'b1;
        @(posedge clk); #2 rx_ready = 1'b0;
        mdl_valid = 1'b0;
    endtask

    task automatic chk_word(input string name, input logic [8:0] d, input logic p, input logic f);
        @(negedge clk);
        chk({name, "_valid"}, 32'(rx_valid), 32'd1);
        chk({name, "_data"}, 32'(rx_data), 32'(d));
        chk({name, "_flags"}, 32'({parity_err, frame_err}), 32'({p, f}));
    endtask

    // Per-cycle compare of DUT outputs against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (rst_last)
                chk("reset_outputs", 32'({rx_data, rx_valid, parity_err, frame_err, overrun, break_det}), 32'd0);
            have_word = 1'b0;
            prev_acc  = 1'b0;
            ov_prev   = 1'b0;
            brk_prev  = 1'b0;
        end else begin
            if (prev_acc) begin
                chk("valid_clear_after_accept", 32'(rx_valid), 32'd0);
                have_word = 1'b0;
            end else if (have_word) begin
                chk("valid_held", 32'(rx_valid), 32'd1);
                if (!rx_valid) have_word = 1'b0;
            end else if (rx_valid) begin
                chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    have_word = 1'b1;
                end
            end
            if (have_word && rx_valid)
                chk("word_contents", 32'({rx_data, parity_err, frame_err}), 32'(cur));
            if (overrun) begin
                ov_seen++;
                chk("overrun_single_cycle", 32'(ov_prev), 32'd0);
                chk("overrun_with_valid", 32'(rx_valid), 32'd1);
            end
            if (break_det) begin
                brk_seen++;
                chk("break_single_cycle", 32'(brk_prev), 32'd0);
            end
            prev_acc = rx_valid && rx_ready;
            ov_prev  = overrun;
            brk_prev = break_det;
        end
        rst_last = rst;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 32'({rx_data, rx_valid, parity_err, frame_err, overrun, break_det}), 32'd0);
        hold(1'b1, 2);

        // 8N1 0xA5, held until accepted
        send(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 2);
        chk_word("a5", 9'h0A5, 1'b0, 1'b0);
        hold(1'b1, 2);
        @(negedge clk);
        chk("a5_still_valid", 32'(rx_valid), 32'd1);
        accept();
        @(negedge clk);
        chk("a5_cleared", 32'(rx_valid), 32'd0);

        // 7E1 0x41: wrong then correct parity bit
        cfg_data_bits = 4'd7;
        cfg_parity    = 2'b01;
        send(9'h041, 7, 1'b1, 1'b1, 1, 1'b1);
        hold(1'b1, 1);
        chk_word("e7_bad", 9'h041, 1'b1, 1'b0);
        accept();
        send(9'h041, 7, 1'b1, 1'b0, 1, 1'b1);
        hold(1'b1, 1);
        chk_word("e7_good", 9'h041, 1'b0, 1'b0);
        accept();

        // 9O2 0x1FF with parity 0
        cfg_data_bits = 4'd9;
        cfg_parity    = 2'b11;
        cfg_stop_bits = 2'd2;
        send(9'h1FF, 9, 1'b1, 1'b0, 2, 1'b1);
        hold(1'b1, 1);
        chk_word("o9", 9'h1FF, 1'b0, 1'b0);
        accept();

        // 8N1 framing error, line stuck low afterwards
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop_bits = 2'd0;
        send(9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
        hold(1'b0, 2);
        chk_word("ferr", 9'h055, 1'b0, 1'b1);
        accept();
        hold(1'b0, 18);
        @(negedge clk);
        chk("ferr_no_restart_low", 32'(rx_valid), 32'd0);
        hold(1'b1, 2);
        @(negedge clk);
        chk("ferr_no_restart_high", 32'(rx_valid), 32'd0);

        // Break: 12 bit-times low, then a normal frame
        send(9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
        hold(1'b0, 2);
        @(negedge clk);
        chk("break_pulse_count", 32'(brk_seen), 32'd1);
        chk("break_no_valid", 32'(rx_valid), 32'd0);
        hold(1'b1, 2);
        send(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 1);
        chk_word("after_break", 9'h03C, 1'b0, 1'b0);
        accept();

        // Back-to-back frames with consumer stalled: second dropped
        send(9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send(9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 1);
        chk_word("overrun_kept", 9'h011, 1'b0, 1'b0);
        chk("overrun_pulse_count", 32'(ov_seen), 32'd1);
        accept();
        @(negedge clk);
        chk("overrun_cleared", 32'(rx_valid), 32'd0);

        // Start glitch of 4 ticks
        uart_rx = 1'b0;
        #(16 * CLK_NS);
        hold(1'b1, 2);
        @(negedge clk);
        chk("glitch_no_word", 32'({rx_valid, parity_err, frame_err}), 32'd0);

        // Pending word, then reset in the middle of a frame's data bits
        send(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 1);
        chk_word("pre_reset", 9'h05A, 1'b0, 1'b0);
        uart_rx = 1'b0;
        #(BIT_NS);
        uart_rx = 1'b1;
        #(BIT_NS);
        uart_rx = 1'b0;
        #(BIT_NS);
        @(posedge clk); #2 rst = 1'b1;
        uart_rx = 1'b1;
        exp_q.delete();
        mdl_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_frame_reset", 32'({rx_data, rx_valid, parity_err, frame_err, overrun, break_det}), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        hold(1'b1, 2);
        send(9'h07E, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 1);
        chk_word("after_reset", 9'h07E, 1'b0, 1'b0);
        accept();
        hold(1'b1, 1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("overrun_total", 32'(ov_seen), 32'(exp_ov));
        chk("break_total", 32'(brk_seen), 32'(exp_brk));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Next-generation UART receiver with runtime-programmable baud divisor, data width, parity and stop bits.
- Adds 3-sample majority voting, framing-error and break detection, and a valid/ready output with an overrun flag.
- Sits between the pad-side serial input and a register or FIFO interface.
- Serial input is asynchronous and is synchronised internally.

Parameters:
- DATA_MAX, 9: maximum data bits per frame (5..9); width of rx_data.
- OVS, 16: oversample ticks per bit; even, >= 8.
- DIV_W, 16: width of cfg_div.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- cfg_div  input  DIV_W  tick period minus 1, in clocks (tick every cfg_div+1 clk)
- cfg_data_bits  input  4  data bits per frame; values below 5 act as 5, above DATA_MAX act as DATA_MAX
- cfg_parity  input  2  bit0: parity enabled; bit1: 0 even, 1 odd
- cfg_stop_bits  input  2  0: 1 stop bit; 1: 1.5 stop bits; 2/3: 2 stop bits
- uart_rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_MAX  received word, LSB-first on the line, right-justified, unused MSBs zero
- rx_valid  output  1  rx_data and error flags are valid
- rx_ready  input  1  consumer accepts the word
- parity_err  output  1  parity mismatch; travels with rx_data
- frame_err  output  1  a checked stop bit sampled 0; travels with rx_data
- overrun  output  1  one-cycle pulse: a completed frame was dropped
- break_det  output  1  one-cycle pulse: break condition detected

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; tick counter is 0.
  - Both synchroniser flops and the previous-line register reset to 1.
  - Reset mid-frame abandons the frame, delivers no data and raises no flags.
- Synchronisation: uart_rx passes through a 2-flop synchroniser; all logic uses the synchronised line (rxs).
- Tick generator:
  - Counter runs 0..cfg_div and emits a tick when count == cfg_div.
  - Counter is held at 0 in IDLE and BREAK.
- Config latching:
  - cfg_data_bits, cfg_parity and cfg_stop_bits are latched at start detection.
  - Config changes mid-frame do not affect the current frame.
  - cfg_div is used live.
- Bit sampling:
  - Each bit spans OVS ticks.
  - rxs is sampled at ticks OVS/2-1, OVS/2 and OVS/2+1 of the bit; the bit value is the 2-of-3 majority.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - Moves to START on an rxs 1->0 transition (previous rxs=1, current rxs=0).
  - A line that is already low does not start a frame.
- START:
  - At the vote: 1 -> IDLE (glitch, nothing reported); 0 -> DATA.
  - Bit timing restarts so DATA votes land mid-bit.
- DATA:
  - Receives N latched data bits, LSB first, each shifted into position.
  - After bit N, goes to PARITY if parity is enabled, else STOP.
- PARITY:
  - One bit is voted.
  - perr = XOR(data bits, parity bit) XOR cfg_parity[1].
- STOP:
  - Stop bit 1 is voted; any 0 sets ferr.
  - 2 stop bits: stop bit 2 is also voted; the frame completes at the stop-bit-2 vote.
  - 1 stop bit: completes at the stop-bit-1 vote.
  - 1.5 stop bits: only stop bit 1 is checked; completes OVS/2 ticks after the stop-bit-1 vote.
- Break:
  - Condition: all data bits 0, parity bit 0 (if enabled), and stop bit 1 voted 0.
  - Sets break_det for 1 cycle at the stop-bit-1 vote.
  - No word is delivered; rx_valid is unchanged.
  - State goes to BREAK, which returns to IDLE when rxs == 1.
- Completion (non-break):
  - One clock after the completing tick, rx_data, parity_err and frame_err load and rx_valid goes to 1.
  - Next state is IDLE.
- Handshake:
  - rx_valid holds until a cycle with rx_valid && rx_ready, then clears next clock.
  - rx_data and the error flags stay stable while rx_valid = 1.
- Overrun:
  - Completion while rx_valid=1 and rx_ready=0: the new word is dropped, old data is retained, and overrun pulses 1 cycle.
  - Completion in the same cycle as rx_valid && rx_ready: the new word loads and rx_valid stays 1, with no overrun.
- A frame with frame_err and nonzero data is delivered normally. If the line stays low afterwards, no new frame starts until rxs returns high and falls again.

Test Plan:
- 8N1, cfg_div=3, OVS=16 (64 clk/bit), send 0xA5, rx_ready=0 -> rx_data=0x0A5, rx_valid=1 held until rx_ready pulse, then 0; parity_err=frame_err=0.
- 7E1, send 0x41 with parity bit 1 (correct is 0) -> rx_data=0x041, parity_err=1; repeat with parity bit 0 -> parity_err=0. 9O2, send 0x1FF with parity 0 -> rx_data=0x1FF, parity_err=0.
- 8N1, send 0x55 with stop bit 0, line then held low 20 bit-times -> rx_data=0x055, frame_err=1; no further rx_valid until line goes high and a new start is sent.
- Line low for 12 bit-times (8N1) -> break_det one-cycle pulse, rx_valid stays 0; after line high, frame 0x3C is received correctly.
- Two back-to-back 8N1 frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x011, overrun one pulse at the second completion; rx_ready=1 -> rx_valid drops.
- Start glitch: line low 4 ticks, then high -> no rx_valid, no flags, back in IDLE. Assert rst mid-DATA -> all outputs 0 and the next frame 0x7E is received correctly.
